// File: rtl/wasm_leb_reader_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : wasm_leb_reader_if                                           |
// | Description : Request/ROM/result bundle for the LEB128 reader. The slave   |
// |               modport is the decoder side; master is the requester + ROM.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface wasm_leb_reader_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 32
);
  logic              start;
  logic              signed_mode;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_read_en;
  logic              rom_ready;
  logic [7:0]        rom_data_out;
  logic              busy;
  logic              done;
  logic              error;
  logic [WIDTH-1:0]  value;
  logic [ADDR_W-1:0] next_addr;
  logic [3:0]        bytes_used;

  modport slave (
    input  start, signed_mode, base_addr, rom_ready, rom_data_out,
    output rom_addr, rom_read_en, busy, done, error, value, next_addr, bytes_used
  );

  modport master (
    output start, signed_mode, base_addr, rom_ready, rom_data_out,
    input  rom_addr, rom_read_en, busy, done, error, value, next_addr, bytes_used
  );
endinterface
`default_nettype wire

// File: rtl/wasm_leb_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : wasm_leb_reader                                              |
// | Description : Fetches one ULEB128/SLEB128 encoding byte by byte from a     |
// |               ready-handshaked ROM and returns the decoded value.          |
// | Options     : LEB_OVERFLOW_CHECK_EN - flag encodings that are too long or  |
// |               carry bits beyond WIDTH (unsigned) via error at done.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module wasm_leb_reader #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 32
) (
  input logic              clk,
  input logic              rst,
  wasm_leb_reader_if.slave bus
);

  localparam int MAX_BYTES = (WIDTH + 6) / 7;
  // Shift stops growing once every payload bit lands at or beyond WIDTH,
  // so the shift register never wraps on very long encodings.
  localparam logic [7:0] c_SHIFT_SAT = 8'(7 * MAX_BYTES);
  localparam logic [7:0] c_WIDTH     = 8'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              rd_en_q, rd_en_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [7:0]        shift_q, shift_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              signed_q, signed_d;
  logic [ADDR_W-1:0] next_addr_q, next_addr_d;
  logic              err_q, err_d;

  logic              w_take;
  logic              w_last;
  logic [WIDTH-1:0]  w_shifted;
  logic [7:0]        w_shift_nxt;
  logic [3:0]        w_cnt_nxt;
  logic [WIDTH-1:0]  w_ext;
  logic              w_ovf;

  // A byte is consumed only on an edge where our own read is outstanding.
  assign w_take      = (state_q == S_FETCH) && rd_en_q && bus.rom_ready;
  assign w_last      = ~bus.rom_data_out[7];
  assign w_shifted   = WIDTH'(bus.rom_data_out[6:0]) << shift_q;
  assign w_shift_nxt = (shift_q >= c_SHIFT_SAT) ? shift_q : shift_q + 8'd7;
  assign w_cnt_nxt   = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
  // Sign fill covers everything above the last payload bit.
  assign w_ext       = (w_shift_nxt < c_WIDTH) ? ({WIDTH{1'b1}} << w_shift_nxt) : '0;

`ifdef LEB_OVERFLOW_CHECK_EN
  localparam int         c_WIDE      = WIDTH + 7;
  localparam logic [3:0] c_MAX_BYTES = 4'(MAX_BYTES);
  logic [c_WIDE-1:0] w_hi;

  // Payload bits that would land at or above WIDTH for this byte.
  assign w_hi  = (c_WIDE'(bus.rom_data_out[6:0]) << shift_q) >> WIDTH;
  assign w_ovf = w_last ? (~signed_q && (|w_hi)) : (w_cnt_nxt == c_MAX_BYTES);
`else
  assign w_ovf = 1'b0;
`endif

  // Next-state and datapath updates; every register holds unless changed.
  always_comb begin
    state_d     = state_q;
    rom_addr_d  = rom_addr_q;
    rd_en_d     = rd_en_q;
    acc_d       = acc_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    signed_d    = signed_q;
    next_addr_d = next_addr_q;
    err_d       = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d    = S_FETCH;
          rom_addr_d = bus.base_addr;
          rd_en_d    = 1'b1;
          acc_d      = '0;
          shift_d    = '0;
          cnt_d      = '0;
          signed_d   = bus.signed_mode;
          err_d      = 1'b0;
        end
      end
      S_FETCH: begin
        if (w_take) begin
          acc_d      = acc_q | w_shifted;
          shift_d    = w_shift_nxt;
          cnt_d      = w_cnt_nxt;
          rom_addr_d = rom_addr_q + 1'b1;
          if (w_last || w_ovf) begin
            state_d     = S_DONE;
            rd_en_d     = 1'b0;
            next_addr_d = rom_addr_q + 1'b1;
            err_d       = w_ovf;
            if (w_last && signed_q && bus.rom_data_out[6]) begin
              acc_d = acc_q | w_shifted | w_ext;
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rom_addr_q  <= '0;
      rd_en_q     <= 1'b0;
      acc_q       <= '0;
      shift_q     <= '0;
      cnt_q       <= '0;
      signed_q    <= 1'b0;
      next_addr_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rom_addr_q  <= rom_addr_d;
      rd_en_q     <= rd_en_d;
      acc_q       <= acc_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      signed_q    <= signed_d;
      next_addr_q <= next_addr_d;
      err_q       <= err_d;
    end
  end

  assign bus.rom_addr    = rom_addr_q;
  assign bus.rom_read_en = rd_en_q;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = (state_q == S_DONE);
  assign bus.error       = err_q;
  assign bus.value       = acc_q;
  assign bus.next_addr   = next_addr_q;
  assign bus.bytes_used  = cnt_q;

endmodule
`default_nettype wire
